// File: rtl/kernel_result_writer_if.sv
// Bundle between the kernel-result source/control side and the result-RAM writer.
// The master side issues frame control and pixels; the slave side is the writer.
interface kernel_result_writer_if #(
  parameter int IN_W = 17
);
  logic                   start;
  logic                   abort;
  logic [1:0]             mode;
  logic                   in_valid;
  logic signed [IN_W-1:0] in_data;
  logic                   wr_en;
  logic [15:0]            wr_addr;
  logic [7:0]             wr_data;
  logic                   busy;
  logic                   done;
  logic [1:0]             frame_mode;
  logic [15:0]            clip_count;

  modport master (
    output start, abort, mode, in_valid, in_data,
    input  wr_en, wr_addr, wr_data, busy, done, frame_mode, clip_count
  );

  modport slave (
    input  start, abort, mode, in_valid, in_data,
    output wr_en, wr_addr, wr_data, busy, done, frame_mode, clip_count
  );
endinterface

// File: rtl/kernel_result_writer.sv
// Captures one frame of signed kernel results, clamps each to 8 bits and writes
// it row-major into the result RAM one cycle after acceptance.
module kernel_result_writer #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int IN_W  = 17
) (
  input  logic                  clk,
  input  logic                  n_rst,
  kernel_result_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int          TOTAL    = IMG_W * IMG_H;
  localparam logic [15:0] LAST_PIX = 16'(TOTAL - 1);

  state_t      state, next_state;
  logic        accept;
  logic        go;
  logic        clipped;
  logic [7:0]  clamped;
  logic [15:0] pix_cnt;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [1:0]  frame_mode_q;
  logic [15:0] clip_count_q;

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // abort outranks both start and pixel acceptance
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    go         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          next_state = RUN;
          go         = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (bus.in_valid) begin
          accept = 1'b1;
          if (pix_cnt == LAST_PIX) next_state = DRAIN;
        end
      end
      DRAIN:   next_state = bus.abort ? IDLE : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    clipped = 1'b0;
    clamped = bus.in_data[7:0];
    if (bus.in_data[IN_W-1]) begin
      clamped = 8'h00;
      clipped = 1'b1;
    end else if (|bus.in_data[IN_W-2:8]) begin
      clamped = 8'hFF;
      clipped = 1'b1;
    end
  end

  // wr_addr/wr_data only move on an accepted pixel, so they hold between writes
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= 8'd0;
      pix_cnt      <= 16'd0;
      frame_mode_q <= 2'd0;
      clip_count_q <= 16'd0;
    end else begin
      wr_en_q <= accept;
      if (go) begin
        pix_cnt      <= 16'd0;
        clip_count_q <= 16'd0;
        frame_mode_q <= bus.mode;
      end
      if (accept) begin
        wr_addr_q <= pix_cnt;
        wr_data_q <= clamped;
        pix_cnt   <= pix_cnt + 16'd1;
        if (clipped && (clip_count_q != 16'hFFFF)) clip_count_q <= clip_count_q + 16'd1;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.frame_mode = frame_mode_q;
  assign bus.clip_count = clip_count_q;

endmodule
